// File: rtl/port_resp.sv
// Output-port responder: grants one requester round-robin, refuses the rest once per request,
// and holds the port busy until the transfer reports done or the watchdog expires.
module port_resp #(
    parameter  int PORTNUM = 16,
    parameter  int TIMEOUT = 1024,
    localparam int GW      = (PORTNUM > 1) ? $clog2(PORTNUM) : 1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [PORTNUM-1:0] i_req,
    input  logic               i_out_ready,
    input  logic               i_done,
    output logic               o_port_ready,
    output logic [PORTNUM-1:0] o_resp,
    output logic [PORTNUM-1:0] o_nresp,
    output logic [GW-1:0]      o_grant_port,
    output logic               o_grant_vld,
    output logic               o_busy,
    output logic               o_timeout
);

    localparam int                 CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]      CNT_MAX = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [PORTNUM-1:0] ONE     = PORTNUM'(1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state, state_n;
    logic [GW-1:0]      last_grant, last_grant_n;
    logic [PORTNUM-1:0] refused, refused_n;
    logic [CW-1:0]      cnt, cnt_n;

    logic [PORTNUM-1:0] elig, grantee_mask;
    logic [PORTNUM-1:0] resp_n, nresp_n;
    logic [GW-1:0]      grant_port_n, winner, idx;
    logic               grant_vld_n, timeout_n, port_ready_n, found;

    // The grantee keeps its request up one cycle past resp; mask it while busy.
    assign grantee_mask = ONE << o_grant_port;
    assign elig = i_req & ~refused & ((state == BUSY) ? ~grantee_mask : {PORTNUM{1'b1}});

    always_comb begin
        winner = '0;
        idx    = '0;
        found  = 1'b0;
        for (int i = 1; i <= PORTNUM; i++) begin
            idx = GW'((int'(last_grant) + i) % PORTNUM);
            if (!found && elig[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        state_n      = state;
        last_grant_n = last_grant;
        cnt_n        = cnt;
        resp_n       = '0;
        nresp_n      = '0;
        grant_port_n = o_grant_port;
        grant_vld_n  = 1'b0;
        timeout_n    = 1'b0;
        case (state)
            IDLE: begin
                if (|elig) begin
                    if (i_out_ready) begin
                        state_n      = BUSY;
                        last_grant_n = winner;
                        cnt_n        = '0;
                        resp_n       = ONE << winner;
                        grant_port_n = winner;
                        grant_vld_n  = 1'b1;
                        nresp_n      = elig & ~(ONE << winner);
                    end else begin
                        nresp_n = elig;
                    end
                end
            end
            BUSY: begin
                nresp_n = elig;
                if (i_done) begin
                    state_n = IDLE;
                end else if (TIMEOUT > 0 && cnt == CNT_MAX) begin
                    state_n   = IDLE;
                    timeout_n = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // A refusal stays latched until the requester drops its line, so each assertion sees one nresp.
    assign refused_n    = (refused & i_req) | nresp_n;
    assign port_ready_n = (state_n == IDLE) & i_out_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            last_grant   <= GW'(PORTNUM - 1);
            refused      <= '0;
            cnt          <= '0;
            o_port_ready <= 1'b0;
            o_resp       <= '0;
            o_nresp      <= '0;
            o_grant_port <= '0;
            o_grant_vld  <= 1'b0;
            o_busy       <= 1'b0;
            o_timeout    <= 1'b0;
        end else begin
            state        <= state_n;
            last_grant   <= last_grant_n;
            refused      <= refused_n;
            cnt          <= cnt_n;
            o_port_ready <= port_ready_n;
            o_resp       <= resp_n;
            o_nresp      <= nresp_n;
            o_grant_port <= grant_port_n;
            o_grant_vld  <= grant_vld_n;
            o_busy       <= (state_n == BUSY);
            o_timeout    <= timeout_n;
        end
    end

endmodule
